// File: rtl/datapath_arbiter_pkg.sv
// Shared types and opcode decoding for the datapath arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_1    = 4'b0001;
  localparam logic [3:0] OP_2    = 4'b0010;
  localparam logic [3:0] OP_3    = 4'b0011;
  localparam logic [3:0] OP_B    = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  function automatic logic is_valid_opcode(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_1) || (op == OP_2) ||
           (op == OP_3) || (op == OP_B);
  endfunction

endpackage

// File: rtl/datapath_arbiter_if.sv
// Requester-side and datapath-side signals of the arbiter, bundled as one interface.
interface datapath_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int DW    = 8
);
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0][OPW-1:0] req_opcode;
  logic [NREQ-1:0][DW-1:0]  req_a;
  logic [NREQ-1:0][DW-1:0]  req_b;
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          ack;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_err;
  logic                     busy;
  logic                     dp_enable;
  logic [OPW-1:0]           dp_opcode;
  logic [DW-1:0]            dp_a;
  logic [DW-1:0]            dp_b;
  logic                     dp_done;
  logic [WIDTH-1:0]         dp_result;

  // Arbiter side
  modport slave (
    input  req, req_opcode, req_a, req_b, dp_done, dp_result,
    output gnt, ack, rsp_data, rsp_err, busy, dp_enable, dp_opcode, dp_a, dp_b
  );

  // Controllers plus datapath side
  modport master (
    output req, req_opcode, req_a, req_b, dp_done, dp_result,
    input  gnt, ack, rsp_data, rsp_err, busy, dp_enable, dp_opcode, dp_a, dp_b
  );
endinterface

// File: rtl/datapath_arbiter_rr_pick.sv
// Rotating-priority finder: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic                    o_found,
  output logic [$clog2(NREQ)-1:0] o_idx
);
  localparam int PW = $clog2(NREQ);

  int w_j;

  // Walk from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_req[PW'(w_j)]) begin
        o_found = 1'b1;
        o_idx   = PW'(w_j);
      end
    end
  end
endmodule

// File: rtl/datapath_arbiter.sv
// Round-robin sharing of one arithmetic datapath among NREQ instruction requesters.
module datapath_arbiter
  import arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int OPW     = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input logic               i_clk,
  input logic               i_reset,   // active-low, asynchronous
  datapath_arbiter_if.slave bus
);
  localparam int         PW      = $clog2(NREQ);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  arb_state_t       r_state, w_next;
  logic [PW-1:0]    r_ptr, r_win, w_idx;
  logic             w_found, w_valid, w_timeout;
  logic [OPW-1:0]   r_op;
  logic [DW-1:0]    r_a, r_b;
  logic [7:0]       r_cnt;
  logic             r_err;
  logic [WIDTH-1:0] r_data;
  logic [NREQ-1:0]  w_onehot;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_valid   = is_valid_opcode(bus.req_opcode[w_idx]);
  assign w_timeout = (r_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_found) w_next = w_valid ? ST_EXEC : ST_RESP;
      ST_EXEC: if (bus.dp_done || w_timeout) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // dp_done has priority over the timeout when both land in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr  <= '0;
      r_win  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_found) begin
          r_win  <= w_idx;
          r_op   <= bus.req_opcode[w_idx];
          r_a    <= bus.req_a[w_idx];
          r_b    <= bus.req_b[w_idx];
          r_cnt  <= '0;
          r_err  <= !w_valid;
          r_data <= '0;
        end
        ST_EXEC: begin
          if (bus.dp_done) begin
            r_data <= bus.dp_result;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_data <= '0;
            r_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RESP: r_ptr <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
        default: ;
      endcase
    end
  end

  assign w_onehot      = NREQ'(1) << r_win;
  assign bus.gnt       = (r_state != ST_IDLE) ? w_onehot : '0;
  assign bus.ack       = (r_state == ST_RESP) ? w_onehot : '0;
  assign bus.rsp_data  = (r_state == ST_RESP) ? r_data : '0;
  assign bus.rsp_err   = (r_state == ST_RESP) && r_err;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.dp_enable = (r_state == ST_EXEC);
  assign bus.dp_opcode = r_op;
  assign bus.dp_a      = r_a;
  assign bus.dp_b      = r_b;
endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: vector table plus multi-cycle sequences.
module tb_datapath_arbiter;
  localparam int NREQ = 4, WIDTH = 16, OPW = 4, DW = 8, TIMEOUT = 5;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  int   got[8];
  int   ngot;

  datapath_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .DW(DW)) bus ();

  datapath_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit");
  end

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        done;
    logic [15:0] res;
    logic [3:0]  e_gnt;
    logic [3:0]  e_ack;
    logic        e_en;
    logic        e_err;
    logic        e_busy;
    logic [15:0] e_data;
    logic        chk_dp;
    logic [3:0]  e_op;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic done, input logic [15:0] res);
    bus.req = req;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_opcode[k] = op;
      bus.req_a[k]      = a;
      bus.req_b[k]      = b;
    end
    bus.dp_done   = done;
    bus.dp_result = res;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({bus.gnt, bus.ack, bus.rsp_err, bus.busy, bus.dp_enable}), 32'd0);
    chk({name, "_data"}, 32'(bus.rsp_data), 32'd0);
    chk({name, "_dp"}, 32'({bus.dp_opcode, bus.dp_a, bus.dp_b}), 32'd0);
  endtask

  // Collects up to n acks in order; each acked requester drops its req right away.
  task automatic watch(input int n, input int max_cyc, input string name);
    ngot = 0;
    for (int c = 0; c < max_cyc && ngot < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
        if (bus.ack[k] && ngot < 8) begin
          got[ngot] = k;
          ngot++;
          bus.req[k] = 1'b0;
        end
      end
    end
    chk({name, "_ack_count"}, 32'(ngot), 32'(n));
  endtask

  initial begin
    int en_cnt;
    logic seen;
    logic [3:0]  ack_v;
    logic        err_v;
    logic [15:0] data_v;

    tbl[0] = '{4'b0100, 4'b0111, 8'h00, 8'h00, 1'b0, 16'h0000,
               4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 4'h0, 8'h00, 8'h00};
    tbl[1] = '{4'b0000, 4'b0111, 8'h00, 8'h00, 1'b0, 16'h0000,
               4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 8'h00, 8'h00};
    tbl[2] = '{4'b0010, 4'b0000, 8'h12, 8'h34, 1'b0, 16'h0000,
               4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 4'h0, 8'h12, 8'h34};
    tbl[3] = '{4'b0010, 4'b0000, 8'h55, 8'h66, 1'b0, 16'h0000,
               4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 4'h0, 8'h12, 8'h34};
    tbl[4] = '{4'b0010, 4'b0000, 8'h55, 8'h66, 1'b0, 16'h0000,
               4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 4'h0, 8'h12, 8'h34};
    tbl[5] = '{4'b0010, 4'b0000, 8'h55, 8'h66, 1'b1, 16'h0046,
               4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1, 16'h0046, 1'b1, 4'h0, 8'h12, 8'h34};
    tbl[6] = '{4'b0000, 4'b0000, 8'h55, 8'h66, 1'b0, 16'h0000,
               4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 8'h12, 8'h34};
    tbl[7] = '{4'b0000, 4'b0000, 8'h55, 8'h66, 1'b1, 16'hBEEF,
               4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 8'h12, 8'h34};
    tbl[8] = '{4'b0000, 4'b0000, 8'h55, 8'h66, 1'b0, 16'h0000,
               4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 8'h12, 8'h34};

    // Reset, then the vector table: invalid op, 3-cycle valid op, stray dp_done.
    rst_n = 1'b0;
    drive(4'b0000, 4'h0, 8'h00, 8'h00, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].req, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].done, tbl[i].res);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i),  32'(bus.gnt),       32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_ack", i),  32'(bus.ack),       32'(tbl[i].e_ack));
      chk($sformatf("v%0d_en", i),   32'(bus.dp_enable), 32'(tbl[i].e_en));
      chk($sformatf("v%0d_err", i),  32'(bus.rsp_err),   32'(tbl[i].e_err));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy),      32'(tbl[i].e_busy));
      chk($sformatf("v%0d_data", i), 32'(bus.rsp_data),  32'(tbl[i].e_data));
      if (tbl[i].chk_dp) begin
        chk($sformatf("v%0d_dp_op", i), 32'(bus.dp_opcode), 32'(tbl[i].e_op));
        chk($sformatf("v%0d_dp_a", i),  32'(bus.dp_a),      32'(tbl[i].e_a));
        chk($sformatf("v%0d_dp_b", i),  32'(bus.dp_b),      32'(tbl[i].e_b));
      end
    end

    // Round-robin: all four pending from ptr=0, immediate dp_done.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'h0, 8'h01, 8'h02, 1'b1, 16'h0003);
    watch(4, 40, "rr4");
    for (int k = 0; k < 4; k++) chk($sformatf("rr4_order%0d", k), 32'(got[k]), 32'(k));
    bus.req = 4'b1001;
    watch(2, 20, "rr2");
    chk("rr2_first", 32'(got[0]), 32'd0);
    chk("rr2_second", 32'(got[1]), 32'd3);

    // Timeout: dp_done never arrives.
    drive(4'b0010, 4'h0, 8'h09, 8'h0A, 1'b0, 16'h1234);
    en_cnt = 0;
    seen   = 1'b0;
    ack_v  = '0;
    err_v  = 1'b0;
    data_v = '1;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (bus.dp_enable) en_cnt++;
      if (bus.ack != 0) begin
        seen   = 1'b1;
        ack_v  = bus.ack;
        err_v  = bus.rsp_err;
        data_v = bus.rsp_data;
        bus.req = 4'b0000;
      end
    end
    chk("to_ack_seen", 32'(seen), 32'd1);
    chk("to_en_cycles", 32'(en_cnt), 32'(TIMEOUT));
    chk("to_ack", 32'(ack_v), 32'b0010);
    chk("to_err", 32'(err_v), 32'd1);
    chk("to_data", 32'(data_v), 32'd0);
    @(negedge clk);

    // Reset in the 2nd EXEC cycle of requester 3 (ptr is 2 at this point).
    drive(4'b1000, 4'h0, 8'h77, 8'h88, 1'b0, 16'h0000);
    @(negedge clk);
    chk("rst_exec1_gnt", 32'(bus.gnt), 32'b1000);
    chk("rst_exec1_en", 32'(bus.dp_enable), 32'd1);
    @(negedge clk);
    chk("rst_exec2_en", 32'(bus.dp_enable), 32'd1);
    rst_n = 1'b0;
    bus.req = 4'b1001;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    chk("rst_no_ack", 32'(bus.ack), 32'd0);
    rst_n = 1'b1;
    bus.dp_done = 1'b1;
    watch(2, 20, "rst_rr");
    chk("rst_rr_first", 32'(got[0]), 32'd0);
    chk("rst_rr_second", 32'(got[1]), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/datapath_arbiter.md
# datapath_arbiter

Shares one arithmetic datapath among `NREQ` instruction requesters such as per-program controllers. It picks one pending request by round-robin, latches its opcode and operands, and rejects illegal opcodes without touching the datapath. It then drives `dp_enable` until `dp_done` or a timeout, and returns the result to the winner with a one-cycle `ack`. It sits between the controllers and the datapath, replacing their direct `enable`/`opcode`/`a`/`b` drive.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: datapath result width.
- `OPW`, 4: opcode width.
- `DW`, 8: operand width (`a`, `b`).
- `TIMEOUT`, 255: maximum EXEC cycles before abort; must fit in 8 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in `NREQ`: per-requester request level, held until `ack`.
- `req_opcode` in `NREQ`×`OPW`: per-requester opcode.
- `req_a` in `NREQ`×`DW`: per-requester operand a.
- `req_b` in `NREQ`×`DW`: per-requester operand b.
- `gnt` out `NREQ`: one-hot, marks the requester being served.
- `ack` out `NREQ`: one-hot, one-cycle pulse marking completion.
- `rsp_data` out `WIDTH`: result, valid while any `ack` is high.
- `rsp_err` out 1: high with `ack` on an invalid opcode or a timeout.
- `busy` out 1: high in any state other than IDLE.
- `dp_enable` out 1: datapath enable.
- `dp_opcode` out `OPW`: opcode to the datapath.
- `dp_a` out `DW`: operand a to the datapath.
- `dp_b` out `DW`: operand b to the datapath.
- `dp_done` in 1: datapath completion.
- `dp_result` in `WIDTH`: datapath result, valid with `dp_done`.

## Operation
- **States:** IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req` bit is high, pick the winner: search from `ptr` upward, wrapping modulo `NREQ`.
  - Latch the winner index and its opcode/a/b into `dp_opcode`/`dp_a`/`dp_b`.
  - Valid opcode: go to EXEC.
  - Invalid opcode: go to RESP with error pending.
- **Valid opcodes:** 4'b0000–4'b0011 and 4'b1011. Everything else, including 4'b1111, is invalid and never enables the datapath.
- **EXEC:**
  - `dp_enable`=1 and `gnt[winner]`=1.
  - Timeout counter starts at 0 on entry and increments each cycle without `dp_done`.
  - On `dp_done`: capture `dp_result` into `rsp_data`, clear error, go to RESP.
  - If the counter reaches `TIMEOUT` first: `rsp_data`=0, error=1, go to RESP.
  - `dp_done` wins over timeout in the same cycle.
- **RESP:**
  - `ack[winner]`=1 and `gnt[winner]`=1; `rsp_err` reflects the error flag.
  - `ptr` <= (winner+1) mod `NREQ`, then go to IDLE.
- **Requester rule:** `req` must be low in the cycle after its `ack`. A `req` still high then counts as a new request.
- **Datapath port hold:** `dp_opcode`/`dp_a`/`dp_b` keep their last latched values outside EXEC; no change while `dp_enable`=0.
- **Ignored inputs:** `dp_done` outside EXEC is ignored. Changes on `req_*` after latching are ignored until the next IDLE.

## Timing
- **Reset values** (asynchronous assert, synchronous release):
  - State IDLE, `ptr`=0.
  - `gnt`, `ack`, `rsp_data`, `rsp_err`, `busy`, `dp_enable`, `dp_opcode`, `dp_a`, `dp_b` all 0.
- **Reset mid-operation:** abandons the transaction with no `ack` issued. The datapath sees `dp_enable` drop immediately.
- **Request to first `dp_enable`:** `req` sampled high at edge k, `dp_enable` high from cycle k+1.
- **Completion to `ack`:** `dp_done` sampled at edge d, `ack` high for exactly the cycle after d. Minimum valid-op latency is 2 cycles from the `req` sample to `ack`.
- **Invalid opcode:** `ack` with `rsp_err`=1 in cycle k+1, `dp_enable` never asserted.
- **Timeout:** the EXEC cycle count equals `TIMEOUT` with no `dp_done`, and `ack`/`rsp_err` follow in the next cycle. The datapath gets exactly `TIMEOUT` enabled cycles.
- **Simultaneous requests:** one grant per transaction, with no bubble beyond the mandatory IDLE cycle between transactions.
- **Fairness:** any continuously asserted `req` is served within `NREQ` transactions.

## Structure
- Package `arbiter_pkg` holds:
  - State enum `arb_state_t`.
  - Opcode constants: `OP_ADD`..`OP_3`, `OP_B`, `OP_HALT`.
  - Function `is_valid_opcode`.
- Sub-module `rr_pick`: combinational rotate-priority finder, (`req`, `ptr`) -> (`found`, `idx`). The arbiter instantiates it once.

## Test plan
- **Invalid opcode, no datapath enable:** reset low then released, `req[2]`=1, opcode 4'b0111 -> `ack[2]` one cycle later with `rsp_err`=1 and `rsp_data`=0; `dp_enable` stays 0 throughout.
- **Valid op, 3-cycle datapath:** `req[1]`, opcode 4'b0000, a=8'h12, b=8'h34, `dp_done` in the 3rd EXEC cycle with `dp_result`=16'h0046 -> `dp_a`/`dp_b`=12/34 held, `ack[1]` with `rsp_data`=16'h0046, `rsp_err`=0.
- **Round-robin fairness:** all four `req` held high, each dropped one cycle after its `ack`, immediate `dp_done` -> grant order 0,1,2,3; then re-raise `req[0]` and `req[3]` with `ptr`=0 -> 0 before 3.
- **Timeout:** `TIMEOUT`=5, `dp_done` never asserted -> exactly 5 cycles of `dp_enable`, then `ack` with `rsp_err`=1, `rsp_data`=0.
- **Reset mid-EXEC:** `reset` pulled low in the 2nd EXEC cycle -> all outputs 0 within the same cycle, no `ack`, and `ptr` returns to 0 so `req[3]` and `req[0]` both pending are served 0 first.
- **Stray `dp_done` and operand change:** `dp_done` pulsed in IDLE -> ignored, no `ack`; `req_a` changed during EXEC -> `dp_a` unchanged.
